debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised multi-channel push-button conditioner; successor to the single-channel debouncer that sits between the board KEY pins and the design top.
- Per channel: 2-flop synchroniser, stability-counter debounce, falling/rising edge pulses, long-press detect, optional auto-repeat.
- Runs on the 50 MHz system clock.
- Keys are active-low: press = debounced level going 0.

Parameters:
- N_CH, 4, number of independent channels.
- STABLE_CYC, 1000000, consecutive cycles a changed input must hold before it is accepted (20 ms at 50 MHz); legal range >= 2.
- LONG_CYC, 50000000, cycles a press must be held before o_long fires (1 s); must be > STABLE_CYC.
- REPEAT_CYC, 10000000, auto-repeat period after a long press (200 ms); >= 1.
- Counter widths are derived internally with $clog2 of each constant.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset. Asynchronous, active-low.
- i_in  input  N_CH  raw key inputs, asynchronous, active-low.
- o_level  output  N_CH  debounced level.
- o_neg  output  N_CH  one-cycle pulse when o_level goes 1->0 (press).
- o_pos  output  N_CH  one-cycle pulse when o_level goes 0->1 (release).
- o_long  output  N_CH  one-cycle pulse, once per press, when the hold reaches LONG_CYC.
- o_repeat  output  N_CH  one-cycle auto-repeat pulses; tied 0 without DEBOUNCE_REPEAT_EN.

Behaviour:
- Reset (async, immediate):
  - sync flops = 1, o_level = all 1.
  - o_neg, o_pos, o_long, o_repeat = 0.
  - All counters = 0.
  - Any in-progress debounce or hold is discarded; no pulse is emitted on or after reset release.
- Synchroniser: sync1 <= i_in, sync2 <= sync1. An input change before edge k is visible in sync2 after edge k+1.
- Debounce, per channel, each edge:
  - sync2 == o_level: cnt <= 0.
  - sync2 != o_level and cnt == STABLE_CYC-1: o_level <= sync2, cnt <= 0, and the matching pulse (o_neg or o_pos) <= 1.
  - Otherwise: cnt <= cnt+1.
- Any glitch back to the o_level value restarts the count from 0.
- Latency: o_level and its pulse update at edge k+1+STABLE_CYC, i.e. STABLE_CYC+2 edges after first sampling.
- All pulses are registered and last exactly one cycle. o_neg and o_pos are never high together on one channel.
- Long press:
  - Hold counter clears in the cycle o_neg is high.
  - Increments each edge while o_level = 0; saturates after o_long fires.
  - o_long pulses exactly LONG_CYC cycles after the o_neg cycle.
  - A release before that point (o_pos) clears the counter; no o_long is emitted.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses. No cross-channel priority or arbitration.
- Release during repeat: o_pos fires and repeat stops immediately. No o_repeat in the o_pos cycle or any later cycle.

Optional Feature:
- Macro DEBOUNCE_REPEAT_EN.
- Defined:
  - After o_long, a per-channel repeat counter runs while held.
  - o_repeat pulses at LONG_CYC + n*REPEAT_CYC cycles after o_neg, n = 1, 2, ...
  - Counter clears on release.
- Undefined: repeat counter logic is not built and o_repeat is constant 0.

Test Plan (STABLE_CYC=4, LONG_CYC=20, REPEAT_CYC=5, N_CH=4):
- Reset: assert i_rst_n=0 with i_in=4'b0000 -> o_level=4'b1111, all pulses 0; after release, o_neg[0] only after a full 6-edge qualification.
- Clean press: i_in[0] 1->0 before edge 0 and held -> o_neg[0]=1 for one cycle after edge 5; o_level[0]=0 from edge 5; no other channel toggles.
- Bounce: i_in[0] low for 3 cycles, high for 1, low for 3, then low steady -> no pulse during the bursts; single o_neg[0] 4 cycles after sync2 settles low; exactly one pulse total.
- Long and repeat: hold i_in[2] low for 40 cycles past o_neg[2] -> o_long[2] once at o_neg+20.
  - With DEBOUNCE_REPEAT_EN: o_repeat[2] at +25, +30, +35, +40.
  - Release: o_pos[2] at release+6; no further o_repeat.
- Simultaneous: i_in[1] and i_in[3] fall in the same cycle -> o_neg[1] and o_neg[3] high in the same cycle; releasing before 20 held cycles gives o_pos and no o_long.
- Mid-operation reset: i_in[0] low for 3 cycles, pulse i_rst_n low for 1 cycle, keep i_in[0] low -> counters cleared; o_neg[0] fires 6 edges after reset release, not earlier.

Source files
------------

// File: rtl/debounce_multi_if.sv
// rtl/debounce_multi_if.sv - raw key inputs and conditioned key outputs for debounce_multi
interface debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] i_in;
    logic [N_CH-1:0] o_level;
    logic [N_CH-1:0] o_neg;
    logic [N_CH-1:0] o_pos;
    logic [N_CH-1:0] o_long;
    logic [N_CH-1:0] o_repeat;

    modport master (output i_in, input o_level, o_neg, o_pos, o_long, o_repeat);
    modport slave  (input i_in, output o_level, o_neg, o_pos, o_long, o_repeat);
endinterface

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel active-low key debouncer with edge, long-press and auto-repeat (DEBOUNCE_REPEAT_EN) pulses
module debounce_multi #(
    parameter int N_CH       = 4,
    parameter int STABLE_CYC = 1000000,
    parameter int LONG_CYC   = 50000000,
    parameter int REPEAT_CYC = 10000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    debounce_multi_if.slave  bus
);
    localparam int CNT_W  = $clog2(STABLE_CYC);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam int REP_W  = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

    logic [N_CH-1:0] level_v, neg_v, pos_v, long_v, rep_v;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic              sync1_q, sync1_d, sync2_q, sync2_d;
        logic              level_q, level_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              neg_q, neg_d, pos_q, pos_d, long_q, long_d;

        always_comb begin
            sync1_d = bus.i_in[g];
            sync2_d = sync1_q;
            level_d = level_q;
            cnt_d   = cnt_q;
            neg_d   = 1'b0;
            pos_d   = 1'b0;
            if (sync2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
                neg_d   = ~sync2_q;
                pos_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            // hold_q == LONG_CYC marks "long already fired" and stops counting
            hold_d = hold_q;
            long_d = 1'b0;
            if (level_q || pos_d) begin
                hold_d = '0;
            end else if (hold_q != HOLD_W'(LONG_CYC)) begin
                hold_d = hold_q + 1'b1;
                long_d = (hold_q == HOLD_W'(LONG_CYC - 1));
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                level_q <= 1'b1;
                cnt_q   <= '0;
                hold_q  <= '0;
                neg_q   <= 1'b0;
                pos_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                level_q <= level_d;
                cnt_q   <= cnt_d;
                hold_q  <= hold_d;
                neg_q   <= neg_d;
                pos_q   <= pos_d;
                long_q  <= long_d;
            end
        end

`ifdef DEBOUNCE_REPEAT_EN
        logic [REP_W-1:0] rep_q, rep_d;
        logic             repeat_q, repeat_d;

        // repeat period starts counting on the edge after o_long fires
        always_comb begin
            rep_d    = rep_q;
            repeat_d = 1'b0;
            if (level_q || pos_d || (hold_q != HOLD_W'(LONG_CYC))) begin
                rep_d = '0;
            end else if (rep_q == REP_W'(REPEAT_CYC - 1)) begin
                rep_d    = '0;
                repeat_d = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rep_q    <= '0;
                repeat_q <= 1'b0;
            end else begin
                rep_q    <= rep_d;
                repeat_q <= repeat_d;
            end
        end

        assign rep_v[g] = repeat_q;
`else
        assign rep_v[g] = 1'b0;
`endif

        assign level_v[g] = level_q;
        assign neg_v[g]   = neg_q;
        assign pos_v[g]   = pos_q;
        assign long_v[g]  = long_q;
    end

    assign bus.o_level  = level_v;
    assign bus.o_neg    = neg_v;
    assign bus.o_pos    = pos_v;
    assign bus.o_long   = long_v;
    assign bus.o_repeat = rep_v;
endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - self-checking bench for debounce_multi against a cycle-count reference model
module tb_debounce_multi;
    localparam int N = 4;
    localparam int S = 4;
    localparam int L = 20;
    localparam int R = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    debounce_multi_if #(.N_CH(N)) bus ();

    debounce_multi #(
        .N_CH(N), .STABLE_CYC(S), .LONG_CYC(L), .REPEAT_CYC(R)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference state: two-sample input delay, accepted level, run lengths
    logic [N-1:0] m_s1, m_s2, m_lvl;
    logic [N-1:0] e_neg, e_pos, e_long, e_rep;
    int run  [N];
    int held [N];

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] nl;
        e_neg = '0; e_pos = '0; e_long = '0; e_rep = '0;
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1; m_lvl = '1;
            for (int c = 0; c < N; c++) begin run[c] = 0; held[c] = 0; end
            return;
        end
        nl = m_lvl;
        for (int c = 0; c < N; c++) begin
            if (m_s2[c] != m_lvl[c]) begin
                run[c]++;
                if (run[c] == S) begin
                    nl[c] = m_s2[c];
                    e_neg[c] = ~m_s2[c];
                    e_pos[c] = m_s2[c];
                    run[c] = 0;
                end
            end else begin
                run[c] = 0;
            end
            if (!m_lvl[c] && !e_pos[c]) begin
                held[c]++;
                e_long[c] = (held[c] == L);
`ifdef DEBOUNCE_REPEAT_EN
                e_rep[c] = (held[c] > L) && ((held[c] - L) % R == 0);
`endif
            end else begin
                held[c] = 0;
            end
        end
        m_lvl = nl;
        m_s2  = m_s1;
        m_s1  = bus.i_in;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("level", bus.o_level, m_lvl);
        chk("neg", bus.o_neg, e_neg);
        chk("pos", bus.o_pos, e_pos);
        chk("long", bus.o_long, e_long);
        chk("repeat", bus.o_repeat, e_rep);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // kind: 0 neg, 1 pos, 2 long; n = edges until pulse, -1 if never seen
    task automatic wait_pulse(input int ch, input int kind, input int maxc, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < maxc) begin
            step();
            n++;
            case (kind)
                0: hit = bus.o_neg[ch];
                1: hit = bus.o_pos[ch];
                default: hit = bus.o_long[ch];
            endcase
        end
        if (!hit) n = -1;
    endtask

    task automatic count_pulses(input int cycles, output int nneg, output int nlong, output int nrep);
        nneg = 0; nlong = 0; nrep = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            nneg  += $countones(bus.o_neg);
            nlong += $countones(bus.o_long);
            nrep  += $countones(bus.o_repeat);
        end
    endtask

    int n, nneg, nlong, nrep, exp_rep;
    int remain [N];

    initial begin
        bus.i_in = '0;
        m_s1 = '1; m_s2 = '1; m_lvl = '1;
        e_neg = '0; e_pos = '0; e_long = '0; e_rep = '0;
        for (int c = 0; c < N; c++) begin run[c] = 0; held[c] = 0; end

        // reset with keys held low
        steps(3);
        chk("rst_level", bus.o_level, 4'hF);
        chk("rst_pulses", bus.o_neg | bus.o_pos | bus.o_long | bus.o_repeat, 4'h0);
        rst_n = 1'b1;
        wait_pulse(0, 0, 20, n);
        chk_int("rst_release_neg_lat", n, 6);
        bus.i_in = '1;
        steps(12);

        // clean press on channel 0
        bus.i_in[0] = 1'b0;
        wait_pulse(0, 0, 20, n);
        chk_int("clean_neg_lat", n, 6);
        chk("clean_neg_only_ch0", bus.o_neg, 4'b0001);
        chk("clean_level", bus.o_level, 4'b1110);
        bus.i_in[0] = 1'b1;
        steps(10);

        // bounce: 3 low, 1 high, then steady low
        bus.i_in[0] = 1'b0; steps(3);
        bus.i_in[0] = 1'b1; step();
        bus.i_in[0] = 1'b0;
        count_pulses(15, nneg, nlong, nrep);
        chk_int("bounce_single_neg", nneg, 1);
        bus.i_in[0] = 1'b1;
        steps(10);

        // long press and auto-repeat on channel 2
        bus.i_in[2] = 1'b0;
        wait_pulse(2, 0, 20, n);
        chk_int("long_press_neg_lat", n, 6);
        wait_pulse(2, 2, 40, n);
        chk_int("long_lat", n, L);
        count_pulses(20, nneg, nlong, nrep);
`ifdef DEBOUNCE_REPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 0;
`endif
        chk_int("long_once", nlong, 0);
        chk_int("repeat_count", nrep, exp_rep);
        bus.i_in[2] = 1'b1;
        wait_pulse(2, 1, 20, n);
        chk_int("release_pos_lat", n, 6);
        count_pulses(15, nneg, nlong, nrep);
        chk_int("no_repeat_after_release", nrep, 0);

        // simultaneous short press on channels 1 and 3
        bus.i_in[1] = 1'b0;
        bus.i_in[3] = 1'b0;
        wait_pulse(1, 0, 20, n);
        chk_int("simul_neg_lat", n, 6);
        chk("simul_neg_both", bus.o_neg, 4'b1010);
        steps(8);
        bus.i_in[1] = 1'b1;
        bus.i_in[3] = 1'b1;
        count_pulses(25, nneg, nlong, nrep);
        chk_int("simul_no_long", nlong, 0);

        // reset in the middle of qualification
        bus.i_in[0] = 1'b0;
        steps(3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_pulse(0, 0, 20, n);
        chk_int("midreset_neg_lat", n, 6);
        bus.i_in[0] = 1'b1;
        steps(10);

        // randomized key activity with occasional reset
        for (int c = 0; c < N; c++) remain[c] = $urandom_range(1, 40);
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (remain[c] == 0) begin
                    bus.i_in[c] = ~bus.i_in[c];
                    remain[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                            : $urandom_range(6, 60);
                end else begin
                    remain[c]--;
                end
            end
            if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
